// File: rtl/send_16_bytes_pkg.sv
// Shared constants and types for the 16-byte block transmitter.
// The receive assembler packs bytes by shifting left (first byte ends up in
// the MSBs), so the transmitter derives its geometry from the same constants
// and sends MSB byte first. A block therefore round-trips unchanged.
package send_16_bytes_pkg;

  // Receive-side geometry: first received byte lands in bits [127:120].
  localparam int unsigned RX_NUM_BYTES = 16;
  localparam int unsigned RX_BYTE_W    = 8;

  // Transmit side mirrors the receiver so both ends agree on byte order.
  localparam int unsigned NUM_BYTES = RX_NUM_BYTES;
  localparam int unsigned BYTE_W    = RX_BYTE_W;
  localparam int unsigned BLOCK_W   = NUM_BYTES * BYTE_W;
  localparam int unsigned CNT_W     = $clog2(NUM_BYTES);

  typedef logic [BLOCK_W-1:0] block_t;
  typedef logic [BYTE_W-1:0]  byte_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/send_16_bytes_if.sv
// Block-load and byte-transmit handshake bundle for send_16_bytes.
//   Enable          : block enable (low aborts / idles)
//   bytesInput      : 128-bit block, sampled on an accepted load
//   bytesLoad       : load request, accepted with blockReady
//   blockReady      : transmitter can accept a block
//   SingleByte      : byte currently offered to the UART TX
//   ByteToSendReady : byte-valid strobe toward the UART TX
//   TxReady         : UART TX can take a byte
//   blockSent       : one-cycle pulse after the last byte transfers
//   busy            : block in flight (SEND or DONE)
// master = block source + UART side (driver), slave = transmitter.
interface send_16_bytes_if;
  import send_16_bytes_pkg::*;

  logic   Enable;
  block_t bytesInput;
  logic   bytesLoad;
  logic   blockReady;
  byte_t  SingleByte;
  logic   ByteToSendReady;
  logic   TxReady;
  logic   blockSent;
  logic   busy;

  modport master (
    output Enable, bytesInput, bytesLoad, TxReady,
    input  blockReady, SingleByte, ByteToSendReady, blockSent, busy
  );

  modport slave (
    input  Enable, bytesInput, bytesLoad, TxReady,
    output blockReady, SingleByte, ByteToSendReady, blockSent, busy
  );

endinterface

// File: rtl/send_16_bytes_block_shift_out.sv
// Block register with parallel load and shift-left by one byte (zero fill).
// The top byte is always the next byte to transmit.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   load_i       : capture data_i (wins over shift_i)
//   shift_i      : drop the top byte, move the rest up
//   data_i       : block to load
//   top_byte_o   : bits [BLOCK_W-1 -: BYTE_W] of the register
module send_16_bytes_block_shift_out
  import send_16_bytes_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   load_i,
  input  logic   shift_i,
  input  block_t data_i,
  output byte_t  top_byte_o
);

  block_t sr_q;
  block_t sr_d;

  // Next-state: load has priority over shift.
  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = data_i;
    end else if (shift_i) begin
      sr_d = {sr_q[BLOCK_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign top_byte_o = sr_q[BLOCK_W-1 -: BYTE_W];

endmodule

// File: rtl/send_16_bytes.sv
// Serializes a 128-bit block into 16 bytes, MSB byte first, for the UART TX.
//   Clk : clock, rising edge
//   Rst : asynchronous active-high reset
//   bus : send_16_bytes_if.slave (block load side + UART byte side)
// The byte-valid, blockSent and busy strobes are decodes of the registered
// state, so they change only on a clock edge or reset. blockReady also
// follows Enable combinationally so a disabled block never accepts a load.
module send_16_bytes
  import send_16_bytes_pkg::*;
(
  input  logic           Clk,
  input  logic           Rst,
  send_16_bytes_if.slave bus
);

  state_e state_q;
  state_e state_d;
  cnt_t   cnt_q;
  cnt_t   cnt_d;
  logic   load_c;
  logic   shift_c;

  // State and byte counter registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter and shift-register controls.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_c  = 1'b0;
    shift_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.Enable && bus.bytesLoad) begin
          load_c  = 1'b1;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        // Abort wins over a coincident transfer.
        if (!bus.Enable) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (bus.TxReady) begin
          shift_c = 1'b1;
          if (cnt_q == CNT_W'(NUM_BYTES - 1)) begin
            // Clear instead of wrapping; the block is complete.
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  send_16_bytes_block_shift_out u_shift (
    .clk_i      (Clk),
    .rst_i      (Rst),
    .load_i     (load_c),
    .shift_i    (shift_c),
    .data_i     (bus.bytesInput),
    .top_byte_o (bus.SingleByte)
  );

  // Status decodes of the registered state.
  assign bus.blockReady      = (state_q == IDLE) && bus.Enable;
  assign bus.ByteToSendReady = (state_q == SEND);
  assign bus.blockSent       = (state_q == DONE);
  assign bus.busy            = (state_q == SEND) || (state_q == DONE);

endmodule

// File: tb/tb_send_16_bytes.sv
// Bench for send_16_bytes: table of blocks with TxReady duty patterns, a byte
// scoreboard fed at load time, a shift-left receive assembler for loopback,
// plus hand-written abort and asynchronous-reset sequences.
module tb_send_16_bytes;

  typedef struct {
    logic [127:0] blk;
    int unsigned  tx_on;
    int unsigned  tx_off;
    int unsigned  exp_cycles;
    bit           poke;
  } vec_t;

  logic Clk = 1'b0;
  logic Rst;

  send_16_bytes_if bus ();

  send_16_bytes dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_xfer   = 0;
  int n_sent   = 0;

  logic [7:0]   exp_q[$];
  logic [127:0] rx_words[$];
  logic [127:0] rx_acc;
  int           rx_cnt;
  vec_t         vecs[7];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s: got nothing, expected an event at %0t", name, $time);
  endtask

  // Observe the UART side just before the coming rising edge.
  task automatic monitor();
    if (bus.ByteToSendReady && bus.TxReady) begin
      if (exp_q.size() == 0) fail("unexpected_byte");
      else check("byte_out", 128'(bus.SingleByte), 128'(exp_q.pop_front()));
      n_xfer++;
      rx_acc = {rx_acc[119:0], bus.SingleByte};
      rx_cnt++;
      if (rx_cnt == 16) begin
        rx_words.push_back(rx_acc);
        rx_cnt = 0;
      end
    end else if (bus.ByteToSendReady) begin
      if (exp_q.size() == 0) fail("valid_without_data");
      else check("byte_hold", 128'(bus.SingleByte), 128'(exp_q[0]));
    end
    if (bus.blockSent) n_sent++;
  endtask

  task automatic step();
    @(negedge Clk);
    monitor();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_block(input logic [127:0] b);
    for (int i = 0; i < 16; i++) exp_q.push_back(b[127-8*i -: 8]);
  endtask

  task automatic discard();
    exp_q.delete();
    rx_cnt = 0;
    rx_acc = '0;
  endtask

  task automatic run_block(input vec_t v);
    int unsigned c;
    int          sent0;
    bit          done;
    c = 0;
    while (!bus.blockReady && c < 40) begin
      step();
      c++;
    end
    check("ready_before_load", 128'(bus.blockReady), 128'(1));
    bus.bytesInput = v.blk;
    bus.bytesLoad  = 1'b1;
    bus.TxReady    = 1'b0;
    push_block(v.blk);
    sent0 = n_sent;
    step();
    bus.bytesLoad = 1'b0;
    check("busy_after_load", 128'(bus.busy), 128'(1));
    check("first_valid", 128'(bus.ByteToSendReady), 128'(1));
    done = 1'b0;
    c = 0;
    while (!done && c < 200) begin
      bus.TxReady = ((c % (v.tx_on + v.tx_off)) < v.tx_on);
      if (v.poke) begin
        bus.bytesLoad  = 1'b1;
        bus.bytesInput = ~v.blk;
        #1;
        check("no_ready_busy", 128'(bus.blockReady), 128'(0));
      end
      step();
      c++;
      done = bus.blockSent;
    end
    bus.bytesLoad = 1'b0;
    bus.TxReady   = 1'b0;
    check("sent_latency", 128'(c), 128'(v.exp_cycles));
    check("queue_drained", 128'(exp_q.size()), 128'(0));
    check("valid_low_done", 128'(bus.ByteToSendReady), 128'(0));
    check("ready_low_done", 128'(bus.blockReady), 128'(0));
    step();
    check("sent_once", 128'(n_sent - sent0), 128'(1));
    check("ready_after_done", 128'(bus.blockReady), 128'(1));
    check("idle_not_busy", 128'(bus.busy), 128'(0));
    if (rx_words.size() == 0) fail("loopback_missing");
    else check("loopback", rx_words.pop_front(), v.blk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish by 200000");
    $fatal(1);
  end

  initial begin
    logic [127:0] blk;
    vec_t         v;
    int           sent0;
    int           x0;

    vecs[0] = '{128'h00112233_44556677_8899AABB_CCDDEEFF, 1, 0, 16, 1'b0};
    vecs[1] = '{128'h00112233_44556677_8899AABB_CCDDEEFF, 1, 3, 61, 1'b0};
    vecs[2] = '{128'h00112233_44556677_8899AABB_CCDDEEFF, 1, 0, 16, 1'b1};
    vecs[3] = '{128'h00112233_44556677_8899AABB_CCDDEEFF, 2, 1, 23, 1'b0};
    vecs[4] = '{{$urandom, $urandom, $urandom, $urandom}, 1, 1, 31, 1'b0};
    vecs[5] = '{{$urandom, $urandom, $urandom, $urandom}, 1, 0, 16, 1'b0};
    vecs[6] = '{{$urandom, $urandom, $urandom, $urandom}, 1, 0, 16, 1'b1};

    bus.Enable     = 1'b1;
    bus.bytesInput = '0;
    bus.bytesLoad  = 1'b0;
    bus.TxReady    = 1'b0;
    rx_acc         = '0;
    rx_cnt         = 0;
    Rst            = 1'b0;
    #1 Rst = 1'b1;
    #1;
    check("rst_byte", 128'(bus.SingleByte), 128'(0));
    check("rst_valid", 128'(bus.ByteToSendReady), 128'(0));
    check("rst_sent", 128'(bus.blockSent), 128'(0));
    check("rst_busy", 128'(bus.busy), 128'(0));
    check("rst_ready_en", 128'(bus.blockReady), 128'(1));
    bus.Enable = 1'b0;
    #1;
    check("rst_ready_dis", 128'(bus.blockReady), 128'(0));
    bus.Enable = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    @(posedge Clk);
    #1;

    // TxReady with nothing to send has no effect.
    bus.TxReady = 1'b1;
    repeat (3) step();
    check("idle_no_xfer", 128'(n_xfer), 128'(0));
    check("idle_no_valid", 128'(bus.ByteToSendReady), 128'(0));
    bus.TxReady = 1'b0;

    // Load is ignored while disabled.
    bus.Enable     = 1'b0;
    bus.bytesLoad  = 1'b1;
    bus.bytesInput = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    #1;
    check("dis_no_ready", 128'(bus.blockReady), 128'(0));
    step();
    check("dis_no_load", 128'(bus.busy), 128'(0));
    bus.bytesLoad = 1'b0;
    bus.Enable    = 1'b1;

    for (int i = 0; i < 7; i++) run_block(vecs[i]);

    // Abort after five transfers, then a fresh all-A5 block.
    blk = 128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F;
    bus.bytesInput = blk;
    bus.bytesLoad  = 1'b1;
    push_block(blk);
    sent0 = n_sent;
    x0    = n_xfer;
    step();
    bus.bytesLoad = 1'b0;
    bus.TxReady   = 1'b1;
    repeat (5) step();
    check("abort_xfers", 128'(n_xfer - x0), 128'(5));
    check("abort_byte5", 128'(bus.SingleByte), 128'(blk[87:80]));
    bus.Enable  = 1'b0;
    bus.TxReady = 1'b0;
    step();
    check("abort_valid_low", 128'(bus.ByteToSendReady), 128'(0));
    check("abort_not_busy", 128'(bus.busy), 128'(0));
    step();
    check("abort_no_sent", 128'(n_sent - sent0), 128'(0));
    check("abort_pending", 128'(exp_q.size()), 128'(11));
    discard();
    bus.Enable = 1'b1;
    v = '{{16{8'hA5}}, 1, 0, 16, 1'b0};
    run_block(v);

    // Asynchronous reset while byte 7 is on offer.
    blk = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    bus.bytesInput = blk;
    bus.bytesLoad  = 1'b1;
    push_block(blk);
    step();
    bus.bytesLoad = 1'b0;
    bus.TxReady   = 1'b1;
    repeat (7) step();
    bus.TxReady = 1'b0;
    check("pre_rst_byte7", 128'(bus.SingleByte), 128'(blk[71:64]));
    #2 Rst = 1'b1;
    #1;
    check("arst_valid", 128'(bus.ByteToSendReady), 128'(0));
    check("arst_byte", 128'(bus.SingleByte), 128'(0));
    check("arst_busy", 128'(bus.busy), 128'(0));
    check("arst_sent", 128'(bus.blockSent), 128'(0));
    discard();
    @(negedge Clk);
    #1 Rst = 1'b0;
    @(posedge Clk);
    #1;
    check("arst_ready", 128'(bus.blockReady), 128'(1));
    v = '{128'h13579BDF_02468ACE_FDB97531_ECA86420, 1, 0, 16, 1'b0};
    run_block(v);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
